// File: rtl/multiply_divide_unit_if.sv
// Command/result bundle between the stage-E controller and the multiply/divide unit.
interface multiply_divide_unit_if;
  logic [3:0]  mulCtrl;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        mulOutputSel;
  logic        busy;
  logic        stallRequest;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mulOutput;

  modport master (
    output mulCtrl, operandA, operandB, mulOutputSel,
    input  busy, stallRequest, hi, lo, mulOutput
  );

  modport slave (
    input  mulCtrl, operandA, operandB, mulOutputSel,
    output busy, stallRequest, hi, lo, mulOutput
  );
endinterface

// File: rtl/multiply_divide_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results commit on the last busy edge; commands are ignored while busy.
module multiply_divide_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  multiply_divide_unit_if.slave bus
);

  localparam logic [3:0] mtDisabled         = 4'd0;
  localparam logic [3:0] mtSetHI            = 4'd1;
  localparam logic [3:0] mtSetLO            = 4'd2;
  localparam logic [3:0] mtMultiply         = 4'd3;
  localparam logic [3:0] mtMultiplyUnsigned = 4'd4;
  localparam logic [3:0] mtDivide           = 4'd5;
  localparam logic [3:0] mtDivideUnsigned   = 4'd6;
  localparam logic [3:0] mtMADD             = 4'd7;
  localparam logic [3:0] mtMADDU            = 4'd8;
  localparam logic [3:0] mtMSUB             = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [3:0]  count, count_n;
  logic [3:0]  op, op_n;
  logic [31:0] opA, opA_n, opB, opB_n;
  logic [31:0] hi, hi_n, lo, lo_n;

  logic [63:0] acc, prod_s, prod_u, result;
  logic [31:0] ua, ub, uq, ur;
  logic        neg_a, neg_b, write_en;
  logic        is_mul, is_div;

  always_comb begin
    is_mul = (bus.mulCtrl == mtMultiply) || (bus.mulCtrl == mtMultiplyUnsigned) ||
             (bus.mulCtrl == mtMADD) || (bus.mulCtrl == mtMADDU) || (bus.mulCtrl == mtMSUB);
    is_div = (bus.mulCtrl == mtDivide) || (bus.mulCtrl == mtDivideUnsigned);
  end

  // Signed divide runs on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
  always_comb begin
    acc    = {hi, lo};
    prod_s = {{32{opA[31]}}, opA} * {{32{opB[31]}}, opB};
    prod_u = {32'b0, opA} * {32'b0, opB};
    neg_a  = (op == mtDivide) && opA[31];
    neg_b  = (op == mtDivide) && opB[31];
    ua     = neg_a ? -opA : opA;
    ub     = neg_b ? -opB : opB;
    uq     = '0;
    ur     = '0;
    if (ub != '0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    result   = acc;
    write_en = 1'b1;
    case (op)
      mtMultiply:         result = prod_s;
      mtMultiplyUnsigned: result = prod_u;
      mtMADD:             result = acc + prod_s;
      mtMADDU:            result = acc + prod_u;
      mtMSUB:             result = acc - prod_s;
      mtDivide, mtDivideUnsigned: begin
        result   = {(neg_a ? -ur : ur), ((neg_a ^ neg_b) ? -uq : uq)};
        write_en = (ub != '0);
      end
      default:            write_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      op    <= mtDisabled;
      opA   <= '0;
      opB   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      op    <= op_n;
      opA   <= opA_n;
      opB   <= opB_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    op_n    = op;
    opA_n   = opA;
    opB_n   = opB;
    hi_n    = hi;
    lo_n    = lo;
    case (state)
      IDLE: begin
        if (is_mul || is_div) begin
          op_n    = bus.mulCtrl;
          opA_n   = bus.operandA;
          opB_n   = bus.operandB;
          count_n = is_mul ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
          state_n = RUN;
        end else if (bus.mulCtrl == mtSetHI) begin
          hi_n = bus.operandA;
        end else if (bus.mulCtrl == mtSetLO) begin
          lo_n = bus.operandA;
        end
      end
      RUN: begin
        count_n = count - 4'd1;
        if (count == 4'd1) begin
          state_n = IDLE;
          if (write_en) begin
            hi_n = result[63:32];
            lo_n = result[31:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (count != '0);
    bus.stallRequest = bus.busy || is_mul || is_div;
    bus.hi           = hi;
    bus.lo           = lo;
    bus.mulOutput    = bus.mulOutputSel ? hi : lo;
  end

endmodule
